// File: rtl/axil_pkg.sv
// Shared types and address helper for the AXI4-Lite register bank.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned shift);
        return (addr - base) >> shift;
    endfunction

endpackage

// File: rtl/axil_regfile_decode.sv
// Combinational address decode: register index and hit flag relative to BASE_ADDR.
module axil_regfile_decode
    import axil_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           IDX_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);

    logic [63:0] full_idx;

    always_comb begin
        full_idx = addr_to_idx(64'(addr_i), 64'(BASE_ADDR), SHIFT);
        // Below-base addresses wrap in the subtraction, so the range check gates them.
        hit_o    = (addr_i >= BASE_ADDR) && (full_idx < 64'(NUM_REGS));
        idx_o    = full_idx[IDX_W-1:0];
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave with NUM_REGS byte-strobed control registers.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam resp_t MISS_RESP = RESP_SLVERR;
`else
    localparam resp_t MISS_RESP = RESP_OKAY;
`endif

    wr_state_t             wr_state_q;
    rd_state_t             rd_state_q;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q, rvalid_q;
    resp_t                 bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_fire, w_fire, commit;
    logic [ADDR_WIDTH-1:0] aw_addr_eff;
    logic [DATA_WIDTH-1:0] wdata_eff, rd_word;
    logic [STRB_W-1:0]     wstrb_eff;
    logic                  aw_hit, ar_hit;
    logic [IDX_W-1:0]      aw_idx, ar_idx;

    assign s_axi_awready = (wr_state_q == W_COLLECT) && !aw_held_q;
    assign s_axi_wready  = (wr_state_q == W_COLLECT) && !w_held_q;
    assign s_axi_arready = (rd_state_q == R_IDLE);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    // Commit uses the live channel when it completes this cycle, so a same-cycle AW+W costs no bubble.
    assign aw_addr_eff = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wdata_eff   = w_held_q  ? wdata_q  : s_axi_wdata;
    assign wstrb_eff   = w_held_q  ? wstrb_q  : s_axi_wstrb;
    assign commit      = (wr_state_q == W_COLLECT) && (aw_held_q || aw_fire)
                         && (w_held_q || w_fire);

    axil_regfile_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS),
        .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_aw_decode (
        .addr_i(aw_addr_eff), .hit_o(aw_hit), .idx_o(aw_idx)
    );

    axil_regfile_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS),
        .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_ar_decode (
        .addr_i(s_axi_araddr), .hit_o(ar_hit), .idx_o(ar_idx)
    );

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (commit && aw_hit && (wstrb_eff != '0)) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (aw_idx == IDX_W'(i)) begin
                    pulse_d[i] = 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wstrb_eff[b]) regs_d[i][8*b +: 8] = wdata_eff[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= W_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            pulse_q    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            pulse_q <= pulse_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            case (wr_state_q)
                W_COLLECT: begin
                    if (commit) begin
                        aw_held_q  <= 1'b1;
                        w_held_q   <= 1'b1;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= aw_hit ? RESP_OKAY : MISS_RESP;
                        wr_state_q <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_axi_awaddr;
                        end
                        if (w_fire) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axi_wdata;
                            wstrb_q  <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        bvalid_q   <= 1'b0;
                        bresp_q    <= RESP_OKAY;
                        wr_state_q <= W_COLLECT;
                    end
                end
                default: wr_state_q <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        rvalid_q   <= 1'b1;
                        rdata_q    <= ar_hit ? rd_word : '0;
                        rresp_q    <= ar_hit ? RESP_OKAY : MISS_RESP;
                        rd_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q   <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (8 x 32-bit, reset value A5A5_0000).
module tb_axil_regfile;

    localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] MISS_RESP = 2'b10;
`else
    localparam logic [1:0] MISS_RESP = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr_pulse;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    axil_regfile #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8),
        .BASE_ADDR(32'h0), .RESET_VALUE(RV)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [7:0] pulses);
        int unsigned n;
        logic aw_f, w_f;
        pulses = '0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid  = 1'b0;
            pulses |= reg_wr_pulse;
            n++;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            pulses |= reg_wr_pulse;
            n++;
        end
        check("bvalid_seen", bvalid, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int unsigned n;
        logic f;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            f = arready;
            @(posedge clk); #1;
            if (f) arvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rvalid_seen", rvalid, 1'b1);
        arvalid = 1'b0;
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        hit;
        int unsigned idx;
        logic [31:0] exp_word;
        logic [7:0]  exp_pulse;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [7];
        logic [255:0] model;
        logic [1:0]   resp;
        logic [7:0]   pulses;
        logic [31:0]  rd;

        // Register 2 already holds 1234_5678 when the table runs (written by the split AW/W sequence).
        vecs[0] = '{32'h00, 32'h1111_1111, 4'hF, 1'b1, 0, 32'h1111_1111, 8'h01, 2'b00};
        vecs[1] = '{32'h04, 32'hFFFF_FFFF, 4'hF, 1'b1, 1, 32'hFFFF_FFFF, 8'h02, 2'b00};
        vecs[2] = '{32'h04, 32'h0000_00AB, 4'h1, 1'b1, 1, 32'hFFFF_FFAB, 8'h02, 2'b00};
        vecs[3] = '{32'h1C, 32'h1234_5678, 4'hC, 1'b1, 7, 32'h1234_0000, 8'h80, 2'b00};
        vecs[4] = '{32'h14, 32'hCAFE_BABE, 4'h0, 1'b1, 5, RV,            8'h00, 2'b00};
        vecs[5] = '{32'h40, 32'h0000_DEAD, 4'hF, 1'b0, 0, 32'h0,         8'h00, MISS_RESP};
        vecs[6] = '{32'h0A, 32'h0000_BEEF, 4'h3, 1'b1, 2, 32'h1234_BEEF, 8'h04, 2'b00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_out", reg_out, {8{RV}});
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", reg_wr_pulse, 8'h00);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // AW on cycle 0, W on cycle 3
        awaddr = 32'h08; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("split_awready_held", awready, 1'b0);
        check("split_wready_open", wready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("split_reg2", reg_out[2*32 +: 32], 32'h1234_5678);
        check("split_pulse", reg_wr_pulse, 8'h04);
        check("split_bvalid", bvalid, 1'b1);
        check("split_bresp", bresp, 2'b00);
        check("split_awready_resp", awready, 1'b0);
        check("split_wready_resp", wready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("split_bvalid_hold", bvalid, 1'b1);
        check("split_pulse_once", reg_wr_pulse, 8'h00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("split_bvalid_done", bvalid, 1'b0);
        check("split_awready_back", awready, 1'b1);
        check("split_wready_back", wready, 1'b1);

        model = {8{RV}};
        model[2*32 +: 32] = 32'h1234_5678;
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulses);
            check($sformatf("vec%0d_pulse", i), pulses, vecs[i].exp_pulse);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            if (vecs[i].hit) model[vecs[i].idx*32 +: 32] = vecs[i].exp_word;
            check($sformatf("vec%0d_reg_out", i), reg_out, model);
            do_read(vecs[i].addr, rd, resp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_word);
            check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        end

        // rvalid/rdata held while rready stays low
        araddr = 32'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("hold_rvalid", rvalid, 1'b1);
        check("hold_rdata", rdata, 32'hFFFF_FFAB);
        check("hold_arready", arready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_rvalid_5", rvalid, 1'b1);
        check("hold_rdata_5", rdata, 32'hFFFF_FFAB);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("hold_rvalid_done", rvalid, 1'b0);
        check("hold_arready_back", arready, 1'b1);

        // Read on the write-commit edge returns the old value
        do_write(32'h0C, 32'h11, 4'hF, resp, pulses);
        awaddr = 32'h0C; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h0C; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_rdata_old", rdata, 32'h11);
        check("rw_reg3_new", reg_out[3*32 +: 32], 32'h22);
        check("rw_both_valid", {bvalid, rvalid}, 2'b11);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(32'h0C, rd, resp);
        check("rw_rdata_new", rd, 32'h22);

        // Asynchronous reset with both responses pending
        awaddr = 32'h18; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h00; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("ar_pre_bvalid", bvalid, 1'b1);
        check("ar_pre_rvalid", rvalid, 1'b1);
        #3;
        aresetn = 1'b0;
        #1;
        check("ar_bvalid_drop", bvalid, 1'b0);
        check("ar_rvalid_drop", rvalid, 1'b0);
        check("ar_reg_out", reg_out, {8{RV}});
        check("ar_awready", awready, 1'b1);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        do_write(32'h10, 32'h55, 4'hF, resp, pulses);
        check("post_rst_pulse", pulses, 8'h10);
        check("post_rst_bresp", resp, 2'b00);
        do_read(32'h10, rd, resp);
        check("post_rst_rdata", rd, 32'h55);
        check("post_rst_reg6", reg_out[6*32 +: 32], RV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave holding NUM_REGS read/write registers at word-aligned offsets from BASE_ADDR.
- Supports byte strobes and fully independent AW/W arrival.
- Provides a full-handshake write response and registered readback of every register.
- Sits between the JTAG-to-AXI master and the DAC datapath; it generalises the single-register JTAG slave to a multi-register control bank.

Parameters:
- DATA_WIDTH, 32: register and bus data width; must be 32 or 64.
- ADDR_WIDTH, 32: AXI address width.
- NUM_REGS, 8: number of registers; must be ≥1.
- BASE_ADDR, 32'h0: byte address of register 0; must be aligned to DATA_WIDTH/8.
- RESET_VALUE, 0: reset value of every register (DATA_WIDTH bits).

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- reg_out  out  NUM_REGS*DATA_WIDTH  all registers, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle a register is updated

Behaviour:
- Reset (async assert, sync-safe release):
  - All registers = RESET_VALUE.
  - awready = wready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; reg_wr_pulse = 0.
  - Any in-flight transaction is dropped.
- Decode:
  - off = addr − BASE_ADDR; idx = off >> log2(DATA_WIDTH/8); low address bits are ignored.
  - Hit when addr ≥ BASE_ADDR and idx < NUM_REGS.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: awready = !aw_held; wready = !w_held. An AW handshake latches the address and sets aw_held. A W handshake latches data and strobe and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (or become held): on a hit, update each byte b with wstrb[b]; pulse reg_wr_pulse[idx]; set bvalid; go to W_RESP. During W_RESP, awready = wready = 0.
  - Latency: AW and W in the same cycle n → register value and bvalid visible in cycle n+1.
  - W_RESP: hold bvalid and bresp until bready. On the handshake, clear held flags and return to W_COLLECT, with awready = wready = 1 the next cycle.
  - wstrb = 0 is a legal no-op: OKAY response, no pulse.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready = 1. The AR handshake in cycle n registers rdata and rresp from register contents as of cycle n; rvalid = 1 in n+1; arready = 0.
  - R_RESP: hold rdata, rresp and rvalid until rready, then return to R_IDLE.
- Simultaneous events:
  - Read and write to the same register with the AR handshake on the write-commit cycle: the read returns the old value.
  - The write and read channels are fully independent; neither blocks the other.
- Miss: writes are dropped with no pulse; reads return rdata = 0. Response code per the optional feature.

Optional Feature:
- Macro AXIL_REGFILE_SLVERR_EN.
- Defined: a miss returns bresp/rresp = 2'b10 (SLVERR).
- Undefined: a miss returns 2'b00 (OKAY). The data effects (dropped write, zero read) are identical in both cases.

Decomposition:
- Package axil_pkg holds:
  - resp_t enum (RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10).
  - wr_state_t {W_COLLECT, W_RESP} and rd_state_t {R_IDLE, R_RESP}.
  - Function addr_to_idx.
- Sub-module axil_regfile_decode: combinational hit/idx from address, BASE_ADDR, NUM_REGS. Instanced twice, once for AW and once for AR.

Test Plan:
- Reset with RESET_VALUE = 32'hA5A5_0000 → all reg_out words = 32'hA5A5_0000; awready = wready = arready = 1; bvalid = rvalid = 0.
- AW addr 0x08 in cycle 0, W data 0x1234_5678 strb 0xF in cycle 3 → reg 2 = 0x1234_5678 and reg_wr_pulse[2] in cycle 4; bvalid held until bready, bresp = 0.
- Reg 1 = 0xFFFF_FFFF, write 0x0000_00AB strb 0x1 → reg 1 = 0xFFFF_FFAB; then read 0x04 → rdata 0xFFFF_FFAB one cycle after AR; rvalid holds 5 cycles with rready = 0.
- Write addr 0x40 (NUM_REGS = 8) data 0xDEAD → no register changes, no pulse; read 0x40 → rdata 0. bresp/rresp = 2'b10 with macro, 2'b00 without.
- Reg 3 = 0x11, write 0x22 to reg 3 with the AR to 0x0C on the commit cycle → rdata 0x11; a subsequent read → 0x22.
- Assert aresetn low while bvalid = 1 and rvalid = 1 → both drop immediately (asynchronously); registers = RESET_VALUE; the next write completes normally.
